// File: rtl/button_debounce_pkg.sv
// Shared definitions for the button debouncer: channel FSM state encoding
// and a small constant helper used to size the hold counter.
package button_debounce_pkg;

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    RELEASED     = ST_RELEASED,
    PRESS_WAIT   = ST_PRESS_WAIT,
    PRESSED      = ST_PRESSED,
    RELEASE_WAIT = ST_RELEASE_WAIT
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One debounce channel: FSM, debounce counter and hold/repeat counter.
// Ports:
//   sysclk        system clock (rising edge)
//   reset         synchronous active-high reset
//   tick          one-cycle debounce tick from the shared prescaler
//   in            synchronized raw input, 1 = pressed
//   level         debounced level
//   press         one-cycle pulse on accepted 0->1
//   release_pulse one-cycle pulse on accepted 1->0
//   hold          one-cycle pulse on hold / auto-repeat
//
// state        | meaning
// RELEASED     | stable released, level = 0
// PRESS_WAIT   | input high, counting ticks before accepting the press
// PRESSED      | stable pressed, level = 1, hold counter running
// RELEASE_WAIT | input low, counting ticks before accepting the release
module debounce_channel
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 10,
  parameter int HOLD_TICKS     = 500,
  parameter int REPEAT_TICKS   = 100
) (
  input  logic sysclk,
  input  logic reset,
  input  logic tick,
  input  logic in,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic hold
);

  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(max_int(HOLD_TICKS, REPEAT_TICKS) + 1);

  // Counters compare against target-1 so the transition lands on the tick
  // that would make the count reach the target; they never exceed it.
  localparam logic [DW-1:0] DEB_END  = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] REP_END  = HW'(REPEAT_TICKS - 1);

  state_t          state;
  logic [DW-1:0]   deb_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            repeating;
  logic [HW-1:0]   hold_end;
  logic            hold_active;

  assign hold_end    = repeating ? REP_END : HOLD_END;
  // With auto-repeat disabled, hold counting stops after the first pulse.
  assign hold_active = !repeating || (REPEAT_TICKS != 0);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state         <= RELEASED;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      repeating     <= 1'b0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      hold          <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      hold          <= 1'b0;
      // An input change always wins over a coincident tick.
      case (state)
        RELEASED: begin
          if (in) begin
            state   <= PRESS_WAIT;
            deb_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!in) begin
            state   <= RELEASED;
            deb_cnt <= '0;
          end else if (tick) begin
            if (deb_cnt == DEB_END) begin
              state     <= PRESSED;
              deb_cnt   <= '0;
              level     <= 1'b1;
              press     <= 1'b1;
              hold_cnt  <= '0;
              repeating <= 1'b0;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!in) begin
            state   <= RELEASE_WAIT;
            deb_cnt <= '0;
          end else if (tick && hold_active) begin
            if (hold_cnt == hold_end) begin
              hold      <= 1'b1;
              hold_cnt  <= '0;
              repeating <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        RELEASE_WAIT: begin
          // hold_cnt is left untouched so a bounce does not restart holding.
          if (in) begin
            state   <= PRESSED;
            deb_cnt <= '0;
          end else if (tick) begin
            if (deb_cnt == DEB_END) begin
              state         <= RELEASED;
              deb_cnt       <= '0;
              level         <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Multi-channel button debouncer with press/release/hold event pulses.
// Ports:
//   sysclk        system clock (rising edge)
//   reset         synchronous active-high reset
//   sync_in       synchronized raw inputs, 1 = pressed
//   level_out     debounced levels
//   press_pulse   one-cycle pulse per accepted press
//   release_pulse one-cycle pulse per accepted release
//   hold_pulse    one-cycle pulse on hold and each auto-repeat
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int HOLD_TICKS     = 500,
  parameter int REPEAT_TICKS   = 100
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] hold_pulse
);

  if (WIDTH < 1) begin : g_bad_width
    $error("button_debounce: WIDTH must be >= 1");
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("button_debounce: TICK_DIV must be >= 2");
  end
  if (DEBOUNCE_TICKS < 1) begin : g_bad_deb
    $error("button_debounce: DEBOUNCE_TICKS must be >= 1");
  end
  if (HOLD_TICKS < 1) begin : g_bad_hold
    $error("button_debounce: HOLD_TICKS must be >= 1");
  end
  if (REPEAT_TICKS < 0) begin : g_bad_rep
    $error("button_debounce: REPEAT_TICKS must be >= 0");
  end

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_END = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PRE_END);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .HOLD_TICKS    (HOLD_TICKS),
      .REPEAT_TICKS  (REPEAT_TICKS)
    ) u_ch (
      .sysclk       (sysclk),
      .reset        (reset),
      .tick         (tick),
      .in           (sync_in[i]),
      .level        (level_out[i]),
      .press        (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .hold         (hold_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: stimulus pushes model predictions,
// a monitor pops and compares each cycle. Two DUTs share the stimulus, one
// with auto-repeat and one with auto-repeat disabled.
module tb_button_debounce;

  localparam int TD  = 4;
  localparam int D   = 3;
  localparam int H   = 5;
  localparam int R_A = 2;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic [1:0] sync_in = 2'b00;
  logic [1:0] lvl_a, prs_a, rel_a, hld_a;
  logic [1:0] lvl_b, prs_b, rel_b, hld_b;

  always #5 sysclk = ~sysclk;

  button_debounce #(.WIDTH(2), .TICK_DIV(TD), .DEBOUNCE_TICKS(D),
                    .HOLD_TICKS(H), .REPEAT_TICKS(R_A)) dut_a (
    .sysclk(sysclk), .reset(reset), .sync_in(sync_in),
    .level_out(lvl_a), .press_pulse(prs_a),
    .release_pulse(rel_a), .hold_pulse(hld_a));

  button_debounce #(.WIDTH(2), .TICK_DIV(TD), .DEBOUNCE_TICKS(D),
                    .HOLD_TICKS(H), .REPEAT_TICKS(0)) dut_b (
    .sysclk(sysclk), .reset(reset), .sync_in(sync_in),
    .level_out(lvl_b), .press_pulse(prs_b),
    .release_pulse(rel_b), .hold_pulse(hld_b));

  typedef struct packed {
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] hld;
  } obs_t;

  typedef struct {
    obs_t a;
    obs_t b;
    int   edge_no;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: level flips once the input has disagreed with it for
  // D ticks (the tick on the disagreeing edge itself is not counted).
  // Held ticks accumulate while pressed and agreeing; hold pulses fall at
  // held = H, H+R, H+2R ...
  int m_edges = 0;
  bit m_level    [2][2];
  bit m_run      [2][2];
  int m_run_ticks[2][2];
  int m_held     [2][2];
  int rep_of     [2] = '{R_A, 0};

  function automatic bit hold_due(input int held, input int rep);
    return (held == H) || (rep > 0 && held > H && ((held - H) % rep) == 0);
  endfunction

  task automatic model_step(input logic [1:0] din, input logic rst,
                            output obs_t oa, output obs_t ob);
    obs_t o[2];
    bit   tick;
    o[0] = '0;
    o[1] = '0;
    if (rst) begin
      m_edges = 0;
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < 2; c++) begin
          m_level[i][c] = 1'b0; m_run[i][c] = 1'b0;
          m_run_ticks[i][c] = 0; m_held[i][c] = 0;
        end
    end else begin
      m_edges++;
      tick = (m_edges % TD) == 0;
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < 2; c++) begin
          if (din[c] == m_level[i][c]) begin
            if (m_level[i][c] && !m_run[i][c] && tick) begin
              m_held[i][c]++;
              if (hold_due(m_held[i][c], rep_of[i])) o[i].hld[c] = 1'b1;
            end
            m_run[i][c] = 1'b0;
            m_run_ticks[i][c] = 0;
          end else if (!m_run[i][c]) begin
            m_run[i][c] = 1'b1;
            m_run_ticks[i][c] = 0;
          end else if (tick) begin
            m_run_ticks[i][c]++;
            if (m_run_ticks[i][c] == D) begin
              m_level[i][c] = din[c];
              if (din[c]) o[i].prs[c] = 1'b1;
              else        o[i].rel[c] = 1'b1;
              m_run[i][c] = 1'b0;
              m_held[i][c] = 0;
            end
          end
          o[i].lvl[c] = m_level[i][c];
        end
    end
    oa = o[0];
    ob = o[1];
  endtask

  task automatic step(input logic [1:0] din, input logic rst);
    exp_t e;
    @(posedge sysclk);
    #3;
    sync_in = din;
    reset   = rst;
    model_step(din, rst, e.a, e.b);
    e.edge_no = m_edges;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [1:0] din, input int n);
    repeat (n) step(din, 1'b0);
  endtask

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Event records taken from the DUT outputs, indexed by edges since reset.
  int last_press0 = -1;
  int last_rel0   = -1;
  int press0_cnt  = 0;
  int rel0_cnt    = 0;
  int sim_cnt     = 0;
  int b_hold0_cnt = 0;
  int hold_edges0[$];

  initial begin : monitor
    exp_t e;
    obs_t act_a, act_b;
    forever begin
      @(posedge sysclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act_a = {lvl_a, prs_a, rel_a, hld_a};
        act_b = {lvl_b, prs_b, rel_b, hld_b};
        vectors++;
        if ({act_a, act_b} !== {e.a, e.b}) begin
          miscompares++;
          $display("FAIL outputs edge %0d: got a=%h b=%h, required a=%h b=%h",
                   e.edge_no, act_a, act_b, e.a, e.b);
        end
        if (prs_a[0] === 1'b1) begin last_press0 = e.edge_no; press0_cnt++; end
        if (rel_a[0] === 1'b1) begin last_rel0 = e.edge_no; rel0_cnt++; end
        if (hld_a[0] === 1'b1) hold_edges0.push_back(e.edge_no);
        if (prs_a[0] === 1'b1 && rel_a[1] === 1'b1) sim_cnt++;
        if (hld_b[0] === 1'b1) b_hold0_cnt++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int low_start;
    logic [1:0] rv;
    int remain[2];

    repeat (3) step(2'b00, 1'b1);

    // Clean press followed by hold and repeat.
    last_press0 = -1;
    hold_edges0.delete();
    run(2'b01, 60);
    check("press_edge", last_press0, 12);
    check("first_hold_gap",
          (hold_edges0.size() > 0) ? hold_edges0[0] - last_press0 : -1, 20);
    check("repeat_gap",
          (hold_edges0.size() > 1) ? hold_edges0[1] - hold_edges0[0] : -1, 8);

    // Release bounce, then sustained release.
    rel0_cnt = 0;
    run(2'b00, 5);
    run(2'b01, 10);
    check("bounce_release_count", rel0_cnt, 0);
    step(2'b00, 1'b0);
    low_start = m_edges;
    run(2'b00, 15);
    check("release_latency_ok",
          (last_rel0 - low_start >= 9 && last_rel0 - low_start <= 12) ? 1 : 0, 1);

    // Glitch rejection.
    press0_cnt = 0;
    run(2'b01, 7);
    run(2'b00, 8);
    check("glitch_press_count", press0_cnt, 0);

    // Reset in the middle of a press.
    repeat (2) step(2'b00, 1'b1);
    run(2'b01, 25);
    rel0_cnt = 0;
    last_press0 = -1;
    repeat (2) step(2'b01, 1'b1);
    run(2'b01, 14);
    check("reset_release_count", rel0_cnt, 0);
    check("press_after_reset", last_press0, 12);

    // Bit 0 pressing while bit 1 releases.
    repeat (2) step(2'b00, 1'b1);
    run(2'b10, 14);
    sim_cnt = 0;
    run(2'b01, 14);
    check("simultaneous_events", sim_cnt, 1);

    // Long hold on the no-repeat instance.
    repeat (2) step(2'b00, 1'b1);
    b_hold0_cnt = 0;
    run(2'b01, 100);
    check("no_repeat_hold_count", b_hold0_cnt, 1);

    // Randomized run-length stimulus with occasional resets.
    repeat (2) step(2'b00, 1'b1);
    rv = 2'b00;
    remain[0] = 0;
    remain[1] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (remain[c] == 0) begin
          rv[c] = ~rv[c];
          remain[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 70)
                                                  : $urandom_range(1, 14);
        end
        remain[c]--;
      end
      step(rv, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end
    step(2'b00, 1'b1);

    // Drain the scoreboard.
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) begin
      @(posedge sysclk);
      #2;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Per-channel debouncer and event generator for mechanical inputs such as push-buttons and DIP switches. It sits directly downstream of the two-flop metastability synchronizer and consumes its already-synchronized vector. For each channel it produces a clean stable level and single-cycle press, release and hold/auto-repeat pulses for control logic on the board. All channels share one millisecond-class tick prescaler.

## Interface
- WIDTH, 1: number of independent input channels.
- TICK_DIV, 50000: sysclk cycles per debounce tick. Must be ≥2.
- DEBOUNCE_TICKS, 10: consecutive ticks of a changed input needed to accept the change. Must be ≥1.
- HOLD_TICKS, 500: ticks of stable-pressed before the first hold_pulse. Must be ≥1.
- REPEAT_TICKS, 100: ticks between subsequent hold_pulses. A value of 0 disables auto-repeat.
- sysclk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sync_in  in  WIDTH  synchronized raw inputs; 1 = pressed.
- level_out  out  WIDTH  debounced stable level.
- press_pulse  out  WIDTH  one-cycle pulse on each accepted 0→1 transition.
- release_pulse  out  WIDTH  one-cycle pulse on each accepted 1→0 transition.
- hold_pulse  out  WIDTH  one-cycle pulse when a press has been held; repeats while the press is held.

## Operation
- Prescaler:
  - Counter counts 0..TICK_DIV-1 and wraps to 0.
  - Internal tick is high for the one cycle where the counter equals TICK_DIV-1.
- Each channel runs an independent FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED, sync_in=1: go to PRESS_WAIT with deb_cnt=0.
  - PRESS_WAIT:
    - sync_in=0 in any cycle: return to RELEASED, deb_cnt=0. No output.
    - Tick with sync_in=1: deb_cnt increments.
    - On the tick where deb_cnt would reach DEBOUNCE_TICKS: go to PRESSED, set level_out=1, pulse press_pulse, clear hold_cnt.
  - PRESSED:
    - Each tick increments hold_cnt.
    - When hold_cnt reaches the target, pulse hold_pulse and reload hold_cnt to 0. The first target is HOLD_TICKS; after that the target is REPEAT_TICKS.
    - If REPEAT_TICKS=0, hold_pulse fires exactly once per press.
    - sync_in=0: go to RELEASE_WAIT with deb_cnt=0. Hold counting pauses.
  - RELEASE_WAIT: mirror of PRESS_WAIT.
    - sync_in=1 in any cycle: return to PRESSED. hold_cnt keeps its value.
    - DEBOUNCE_TICKS ticks with sync_in=0: go to RELEASED, set level_out=0, pulse release_pulse.
- A tick in the same cycle as an input change: the change takes priority. The counter clears and does not increment.
- Counter widths:
  - deb_cnt is $clog2(DEBOUNCE_TICKS+1) bits.
  - hold_cnt is $clog2(max(HOLD_TICKS,REPEAT_TICKS)+1) bits.
  - Neither counter can overflow; each saturates at its target.
- Reset, at any time including mid-debounce or mid-hold:
  - Every channel goes to RELEASED.
  - All counters, including the prescaler, clear to 0.
  - All outputs go to 0 on the next edge.
  - No release_pulse is generated by reset.
  - An input held high through reset is re-debounced and then produces a normal press_pulse.

## Timing
- Reset values: level_out, press_pulse, release_pulse and hold_pulse are all 0.
- All outputs are registered and change only on sysclk edges.
- Pulses are exactly one cycle wide and assert on the same edge as the corresponding level_out change.
- The first tick comes TICK_DIV cycles after reset deasserts; after that, one tick every TICK_DIV cycles.
- Press latency from sync_in stable high to level_out=1 is between (DEBOUNCE_TICKS-1)·TICK_DIV+1 and DEBOUNCE_TICKS·TICK_DIV cycles. Release latency is identical.
- The first hold_pulse comes exactly HOLD_TICKS·TICK_DIV cycles after press_pulse, provided there is no release glitch. Repeats follow every REPEAT_TICKS·TICK_DIV cycles.
- Channels are fully independent. Simultaneous events on different bits each produce their own pulses in the same cycle.

## Structure
- Shared package/header holds the channel FSM state encoding as localparams (2 bits: RELEASED=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3).
- Top level contains:
  - the shared prescaler;
  - parameter legality checks that stop elaboration on illegal values;
  - a generate loop instantiating WIDTH copies of sub-module debounce_channel.
- debounce_channel has ports sysclk, reset, tick, in, level, press, release, hold, and contains the FSM plus deb_cnt and hold_cnt.

## Test plan
All scenarios use TICK_DIV=4, DEBOUNCE_TICKS=3, HOLD_TICKS=5, REPEAT_TICKS=2, WIDTH=2.
- Clean press: sync_in[0]=1 from cycle 1 after reset → level_out[0] rises with a one-cycle press_pulse[0] at cycle 12 (the third tick). Bit 1 stays 0.
- Glitch rejection: sync_in[0] high for 7 cycles, then low → level_out and all pulses stay 0.
- Hold/repeat: keep sync_in[0] high after the press → hold_pulse[0] 20 cycles after press_pulse, then every 8 cycles. The press-to-first-hold interval does not depend on the release glitch in the next scenario.
- Release bounce: while pressed, drop sync_in[0] for 5 cycles, then restore → no release_pulse and level stays 1. A sustained low → release_pulse within 9–12 cycles.
- Reset mid-hold: assert reset while level_out[0]=1 → all outputs 0 on the next edge, no release_pulse. Deassert reset with input still high → press_pulse at cycle 12 after reset release.
- Simultaneous channels: bit 0 pressing and bit 1 releasing with aligned timing → press_pulse[0] and release_pulse[1] in the same cycle. Separately, with REPEAT_TICKS=0, a long hold gives exactly one hold_pulse.
